// File: rtl/mcp_pkg.sv
// Shared definitions for the mcp_core microcontroller: opcodes, branch conditions and FSM states.
package mcp_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_ADD   = 4'h1;
    localparam logic [3:0] OP_SUB   = 4'h2;
    localparam logic [3:0] OP_NAND  = 4'h3;
    localparam logic [3:0] OP_SHL   = 4'h4;
    localparam logic [3:0] OP_SHR   = 4'h5;
    localparam logic [3:0] OP_OUT   = 4'h6;
    localparam logic [3:0] OP_IN    = 4'h7;
    localparam logic [3:0] OP_MOV   = 4'h8;
    localparam logic [3:0] OP_BR    = 4'h9;
    localparam logic [3:0] OP_BCOND = 4'hA;
    localparam logic [3:0] OP_BSR   = 4'hB;
    localparam logic [3:0] OP_RET   = 4'hC;
    localparam logic [3:0] OP_LOAD  = 4'hD;
    localparam logic [3:0] OP_STORE = 4'hE;
    localparam logic [3:0] OP_LDI   = 4'hF;

    // Condition codes live in the ra field of a conditional branch.
    localparam logic [1:0] COND_Z     = 2'd0;
    localparam logic [1:0] COND_C     = 2'd1;
    localparam logic [1:0] COND_N     = 2'd2;
    localparam logic [1:0] COND_NEVER = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_HALT     = 2'd2
    } state_e;

endpackage

// File: rtl/mcp_call_stack.sv
// Return-address stack for bsr/ret; push and pop are ignored when they would overflow or underflow.
module mcp_call_stack
    import mcp_pkg::*;
#(
    parameter int DW = 8,
    parameter int SD = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] pushData,
    output logic          full,
    output logic          empty,
    output logic [DW-1:0] top
);
    localparam int PW = $clog2(SD + 1);
    localparam int AW = $clog2(SD);

    logic [PW-1:0] sp_q;
    logic [DW-1:0] entries_q [SD];

    assign full  = (sp_q == PW'(SD));
    assign empty = (sp_q == '0);
    assign top   = empty ? '0 : entries_q[AW'(sp_q - 1'b1)];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sp_q <= '0;
        end else if (push && !full) begin
            sp_q <= sp_q + 1'b1;
        end else if (pop && !empty) begin
            sp_q <= sp_q - 1'b1;
        end
    end

    // Entry storage needs no reset: only slots below the stack pointer are ever read.
    always_ff @(posedge clk) begin
        if (rst && push && !full) begin
            entries_q[AW'(sp_q)] <= pushData;
        end
    end

endmodule

// File: rtl/mcp_core.sv
// Four-register accumulator-style microcontroller core with flags, call stack and a
// handshaked data-memory port; halts permanently on call-stack misuse.
module mcp_core
    import mcp_pkg::*;
#(
    parameter int DW = 8,
    parameter int SD = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW+7:0] instr,
    input  logic          instrValid,
    input  logic [DW-1:0] fromInputPort,
    input  logic [DW-1:0] fromDataMemory,
    input  logic          memAck,
    output logic [DW-1:0] pc,
    output logic [DW-1:0] toOutputPort,
    output logic          outWrite,
    output logic [DW-1:0] toDataMemoryAddress,
    output logic [DW-1:0] toDataMemory,
    output logic          memReq,
    output logic          memWrite,
    output logic          fault
);
    state_e        state_q, state_d;
    logic [DW-1:0] pc_q, pc_d;
    logic [DW-1:0] regs_q [4];
    logic [DW-1:0] regs_d [4];
    logic          z_q, z_d, n_q, n_d, c_q, c_d;
    logic [DW-1:0] outData_q, outData_d, memAddr_q, memAddr_d, memData_q, memData_d;
    logic          memReq_q, memReq_d, memWrite_q, memWrite_d, fault_q, fault_d;
    logic [1:0]    memRa_q, memRa_d;

    logic [3:0]    opcode;
    logic [1:0]    ra, rb;
    logic [DW-1:0] imm, opA, opB, pcInc, stackTop;
    logic [DW:0]   aluWide;
    logic          condTaken, stackPush, stackPop, stackFull, stackEmpty;

    assign opcode = instr[7:4];
    assign ra     = instr[3:2];
    assign rb     = instr[1:0];
    assign imm    = instr[DW+7:8];
    assign opA    = regs_q[ra];
    assign opB    = regs_q[rb];
    assign pcInc  = pc_q + 1'b1;

    // Bit DW of aluWide carries the C flag: carry, borrow, or the bit shifted out.
    always_comb begin
        aluWide = '0;
        case (opcode)
            OP_ADD:  aluWide = {1'b0, opA} + {1'b0, opB};
            OP_SUB:  aluWide = {1'b0, opA} - {1'b0, opB};
            OP_NAND: aluWide = {1'b0, ~(opA & opB)};
            OP_SHL:  aluWide = {opB, 1'b0};
            OP_SHR:  aluWide = {opB[0], 1'b0, opB[DW-1:1]};
            default: aluWide = '0;
        endcase
    end

    always_comb begin
        case (ra)
            COND_Z:  condTaken = z_q;
            COND_C:  condTaken = c_q;
            COND_N:  condTaken = n_q;
            default: condTaken = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        regs_d     = regs_q;
        z_d        = z_q;
        n_d        = n_q;
        c_d        = c_q;
        outData_d  = outData_q;
        memAddr_d  = memAddr_q;
        memData_d  = memData_q;
        memReq_d   = memReq_q;
        memWrite_d = memWrite_q;
        memRa_d    = memRa_q;
        fault_d    = fault_q;
        stackPush  = 1'b0;
        stackPop   = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (instrValid) begin
                    pc_d = pcInc;
                    case (opcode)
                        OP_ADD, OP_SUB, OP_NAND, OP_SHL, OP_SHR: begin
                            regs_d[ra] = aluWide[DW-1:0];
                            z_d        = (aluWide[DW-1:0] == '0);
                            n_d        = aluWide[DW-1];
                            c_d        = aluWide[DW];
                        end
                        OP_OUT:   outData_d  = opA;
                        OP_IN:    regs_d[ra] = fromInputPort;
                        OP_MOV:   regs_d[ra] = opB;
                        OP_BR:    pc_d       = imm;
                        OP_BCOND: if (condTaken) pc_d = imm;
                        OP_BSR: begin
                            if (stackFull) begin
                                pc_d    = pc_q;
                                fault_d = 1'b1;
                                state_d = ST_HALT;
                            end else begin
                                stackPush = 1'b1;
                                pc_d      = imm;
                            end
                        end
                        OP_RET: begin
                            if (stackEmpty) begin
                                pc_d    = pc_q;
                                fault_d = 1'b1;
                                state_d = ST_HALT;
                            end else begin
                                stackPop = 1'b1;
                                pc_d     = stackTop;
                            end
                        end
                        OP_LOAD, OP_STORE: begin
                            pc_d       = pc_q;
                            memReq_d   = 1'b1;
                            memWrite_d = (opcode == OP_STORE);
                            memAddr_d  = imm;
                            memRa_d    = ra;
                            if (opcode == OP_STORE) memData_d = opA;
                            state_d    = ST_MEM_WAIT;
                        end
                        OP_LDI:   regs_d[ra] = imm;
                        default: ;
                    endcase
                end
            end
            ST_MEM_WAIT: begin
                if (memAck) begin
                    if (!memWrite_q) regs_d[memRa_q] = fromDataMemory;
                    memReq_d   = 1'b0;
                    memWrite_d = 1'b0;
                    pc_d       = pcInc;
                    state_d    = ST_RUN;
                end
            end
            default: state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RUN;
            pc_q       <= '0;
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
            z_q        <= 1'b0;
            n_q        <= 1'b0;
            c_q        <= 1'b0;
            outData_q  <= '0;
            memAddr_q  <= '0;
            memData_q  <= '0;
            memReq_q   <= 1'b0;
            memWrite_q <= 1'b0;
            memRa_q    <= '0;
            fault_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            regs_q     <= regs_d;
            z_q        <= z_d;
            n_q        <= n_d;
            c_q        <= c_d;
            outData_q  <= outData_d;
            memAddr_q  <= memAddr_d;
            memData_q  <= memData_d;
            memReq_q   <= memReq_d;
            memWrite_q <= memWrite_d;
            memRa_q    <= memRa_d;
            fault_q    <= fault_d;
        end
    end

    mcp_call_stack #(.DW(DW), .SD(SD)) u_callStack (
        .clk      (clk),
        .rst      (rst),
        .push     (stackPush),
        .pop      (stackPop),
        .pushData (pcInc),
        .full     (stackFull),
        .empty    (stackEmpty),
        .top      (stackTop)
    );

    // The output strobe is combinational, so the port shows Ra live during the write cycle.
    assign outWrite            = rst && (state_q == ST_RUN) && instrValid && (opcode == OP_OUT);
    assign toOutputPort        = outWrite ? opA : outData_q;
    assign pc                  = pc_q;
    assign toDataMemoryAddress = memAddr_q;
    assign toDataMemory        = memData_q;
    assign memReq              = memReq_q;
    assign memWrite            = memWrite_q;
    assign fault               = fault_q;

endmodule

// File: tb/tb_mcp_core.sv
// Randomised and directed bench for mcp_core: a behavioural model predicts port writes and
// memory requests into queues that a negedge monitor drains and compares.
`timescale 1ns/1ps
module tb_mcp_core;
    localparam int DW = 8;
    localparam int SD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW+7:0] instr = '0;
    logic          instrValid = 1'b0;
    logic [DW-1:0] fromInputPort = '0;
    logic [DW-1:0] fromDataMemory = '0;
    logic          memAck = 1'b0;
    logic [DW-1:0] pc, toOutputPort, toDataMemoryAddress, toDataMemory;
    logic          outWrite, memReq, memWrite, fault;

    mcp_core #(.DW(DW), .SD(SD)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .instr               (instr),
        .instrValid          (instrValid),
        .fromInputPort       (fromInputPort),
        .fromDataMemory      (fromDataMemory),
        .memAck              (memAck),
        .pc                  (pc),
        .toOutputPort        (toOutputPort),
        .outWrite            (outWrite),
        .toDataMemoryAddress (toDataMemoryAddress),
        .toDataMemory        (toDataMemory),
        .memReq              (memReq),
        .memWrite            (memWrite),
        .fault               (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic       wr;
    } memExp_t;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  outQ [$];
    memExp_t     memQ [$];
    memExp_t     curMem;
    logic [7:0]  outE;
    int          memReqLen = 0;
    int          memWriteLen = 0;
    logic        memReqSeen = 1'b0;

    int unsigned mR [4];
    bit          mZ, mN, mC, mHalt;
    int unsigned mPc;
    int unsigned mStack [$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [15:0] mk(input logic [3:0] op, input logic [1:0] ra,
                                       input logic [1:0] rb, input logic [7:0] imm);
        return {imm, op, ra, rb};
    endfunction

    task automatic modelReset();
        for (int i = 0; i < 4; i++) mR[i] = 0;
        mZ = 0; mN = 0; mC = 0; mHalt = 0; mPc = 0;
        mStack.delete();
        outQ.delete();
        memQ.delete();
    endtask

    // Instruction semantics in plain integer arithmetic on 8-bit values.
    task automatic modelStep(input logic [15:0] ins, input logic [7:0] port, input logic [7:0] memVal);
        int unsigned op, ra, rb, imm, a, b, res, nextPc;
        bit cout, alu;
        if (mHalt) return;
        op = ins[7:4]; ra = ins[3:2]; rb = ins[1:0]; imm = ins[15:8];
        a = mR[ra]; b = mR[rb];
        res = 0; cout = 0; alu = 0;
        nextPc = (mPc + 1) % 256;
        case (op)
            1:  begin res = a + b; cout = (res > 255); res = res % 256; alu = 1; end
            2:  begin cout = (a < b); res = (a + 256 - b) % 256; alu = 1; end
            3:  begin res = 255 - (a & b); alu = 1; end
            4:  begin res = (b * 2) % 256; cout = (b >= 128); alu = 1; end
            5:  begin res = b / 2; cout = (b % 2 == 1); alu = 1; end
            6:  outQ.push_back(8'(a));
            7:  mR[ra] = port;
            8:  mR[ra] = b;
            9:  nextPc = imm;
            10: if ((ra == 0 && mZ) || (ra == 1 && mC) || (ra == 2 && mN)) nextPc = imm;
            11: if (mStack.size() >= SD) begin mHalt = 1; nextPc = mPc; end
                else begin mStack.push_back(nextPc); nextPc = imm; end
            12: if (mStack.size() == 0) begin mHalt = 1; nextPc = mPc; end
                else nextPc = mStack.pop_back();
            13: begin memQ.push_back('{addr: 8'(imm), data: 8'h00, wr: 1'b0}); mR[ra] = memVal; nextPc = mPc; end
            14: begin memQ.push_back('{addr: 8'(imm), data: 8'(a), wr: 1'b1}); nextPc = mPc; end
            15: mR[ra] = imm;
            default: ;
        endcase
        if (alu) begin
            mR[ra] = res; mZ = (res == 0); mN = (res >= 128); mC = cout;
        end
        if (op == 13 || op == 14) mPc = (mPc + 1) % 256;
        else mPc = nextPc;
    endtask

    task automatic doReset();
        rst = 1'b0;
        instrValid = 1'b0;
        memAck = 1'b0;
        #2;
        checkOutput("rstPc", pc, 0);
        checkOutput("rstOutPort", toOutputPort, 0);
        checkOutput("rstOutWrite", outWrite, 0);
        checkOutput("rstMemAddr", toDataMemoryAddress, 0);
        checkOutput("rstMemData", toDataMemory, 0);
        checkOutput("rstMemReq", memReq, 0);
        checkOutput("rstMemWrite", memWrite, 0);
        checkOutput("rstFault", fault, 0);
        modelReset();
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic applyIdle(input int n);
        instrValid = 1'b0;
        repeat (n) begin
            instr = 16'($urandom);
            memAck = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        memAck = 1'b0;
        checkOutput("idlePc", pc, mPc);
        checkOutput("idleMemReq", memReq, 0);
    endtask

    task automatic applyStimulus(input logic [15:0] ins, input logic [7:0] port,
                                 input logic [7:0] memVal, input int ackDelay);
        bit          wasHalt;
        int unsigned pcBefore;
        wasHalt  = mHalt;
        pcBefore = mPc;
        instr = ins; instrValid = 1'b1;
        fromInputPort = port; fromDataMemory = memVal;
        modelStep(ins, port, memVal);
        @(posedge clk); #1;
        if (!wasHalt && (ins[7:4] == 4'hD || ins[7:4] == 4'hE)) begin
            repeat (ackDelay) begin
                instrValid = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            checkOutput("memWaitPc", pc, pcBefore);
            checkOutput("memWaitReq", memReq, 1);
            memAck = 1'b1;
            @(posedge clk); #1;
            memAck = 1'b0;
            checkOutput("memDoneReq", memReq, 0);
        end
        instrValid = 1'b0;
        checkOutput("pc", pc, mPc);
        checkOutput("fault", fault, mHalt);
    endtask

    // Monitor: drains the expectation queues whenever the core presents a write or request.
    always @(negedge clk) begin
        if (!rst) begin
            memReqSeen = 1'b0;
        end else begin
            if (outWrite) begin
                if (outQ.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL outUnexpected: got write of %0h, expected no write", toOutputPort);
                end else begin
                    outE = outQ.pop_front();
                    checkOutput("outData", toOutputPort, outE);
                end
            end
            if (memReq && !memReqSeen) begin
                memReqLen   = 1;
                memWriteLen = memWrite ? 1 : 0;
                if (memQ.size() == 0) begin
                    checks++; errors++;
                    $display("[TB] FAIL memUnexpected: got request to %0h, expected none", toDataMemoryAddress);
                end else begin
                    curMem = memQ.pop_front();
                    checkOutput("memAddr", toDataMemoryAddress, curMem.addr);
                    checkOutput("memWrite", memWrite, curMem.wr);
                    if (curMem.wr) checkOutput("memData", toDataMemory, curMem.data);
                end
            end else if (memReq) begin
                memReqLen++;
                if (memWrite) memWriteLen++;
                checkOutput("memAddrHold", toDataMemoryAddress, curMem.addr);
            end
            memReqSeen = memReq;
        end
    end

    initial begin
        logic [3:0] op;
        #1;
        doReset();

        // Basic add with no flags, followed by three untaken conditional branches.
        applyStimulus(mk(4'hF, 2'd0, 2'd0, 8'h02), 8'h00, 8'h00, 0);
        applyStimulus(mk(4'hF, 2'd1, 2'd0, 8'h04), 8'h00, 8'h00, 0);
        applyStimulus(mk(4'h1, 2'd0, 2'd1, 8'h00), 8'h00, 8'h00, 0);
        checkOutput("addPc", pc, 3);
        outQ.push_back(8'h06);
        instr = mk(4'h6, 2'd0, 2'd3, 8'h00); instrValid = 1'b1;
        @(posedge clk); #1;
        mPc = 4;
        applyStimulus(mk(4'hA, 2'd0, 2'd0, 8'h50), 8'h00, 8'h00, 0);
        applyStimulus(mk(4'hA, 2'd1, 2'd0, 8'h50), 8'h00, 8'h00, 0);
        applyStimulus(mk(4'hA, 2'd2, 2'd0, 8'h50), 8'h00, 8'h00, 0);
        checkOutput("noBranchPc", pc, 7);

        // Wrapping add: zero result with carry, then taken carry and zero branches.
        doReset();
        applyStimulus(mk(4'hF, 2'd0, 2'd0, 8'hFF), 8'h00, 8'h00, 0);
        applyStimulus(mk(4'hF, 2'd1, 2'd0, 8'h01), 8'h00, 8'h00, 0);
        applyStimulus(mk(4'h1, 2'd0, 2'd1, 8'h00), 8'h00, 8'h00, 0);
        applyStimulus(mk(4'hA, 2'd1, 2'd0, 8'h40), 8'h00, 8'h00, 0);
        checkOutput("brcPc", pc, 8'h40);
        applyStimulus(mk(4'h6, 2'd0, 2'd0, 8'h00), 8'h00, 8'h00, 0);
        applyStimulus(mk(4'hA, 2'd0, 2'd0, 8'h20), 8'h00, 8'h00, 0);
        checkOutput("brzPc", pc, 8'h20);
        applyStimulus(mk(4'hA, 2'd3, 2'd0, 8'h99), 8'h00, 8'h00, 0);
        checkOutput("neverPc", pc, 8'h21);

        // Store held for four request cycles, then a load read back through the port.
        doReset();
        applyStimulus(mk(4'hF, 2'd2, 2'd0, 8'h08), 8'h00, 8'h00, 0);
        applyStimulus(mk(4'hE, 2'd2, 2'd1, 8'h03), 8'h00, 8'h00, 3);
        checkOutput("storeReqLen", memReqLen, 4);
        checkOutput("storeWrLen", memWriteLen, 4);
        checkOutput("storePc", pc, 2);
        applyStimulus(mk(4'hD, 2'd1, 2'd2, 8'h33), 8'h00, 8'hA5, 1);
        applyStimulus(mk(4'h6, 2'd1, 2'd0, 8'h00), 8'h00, 8'h00, 0);

        // Nested calls and returns that stay inside the stack.
        doReset();
        applyStimulus(mk(4'hB, 2'd0, 2'd0, 8'h10), 8'h00, 8'h00, 0);
        applyStimulus(mk(4'hB, 2'd0, 2'd0, 8'h30), 8'h00, 8'h00, 0);
        applyStimulus(mk(4'hC, 2'd0, 2'd0, 8'h00), 8'h00, 8'h00, 0);
        checkOutput("ret1Pc", pc, 8'h11);
        applyStimulus(mk(4'hC, 2'd0, 2'd0, 8'h00), 8'h00, 8'h00, 0);
        checkOutput("ret2Pc", pc, 8'h01);

        // Stack overflow on the fifth call; everything afterwards is ignored.
        doReset();
        for (int i = 1; i <= 5; i++) applyStimulus(mk(4'hB, 2'd0, 2'd0, 8'(i * 16)), 8'h00, 8'h00, 0);
        checkOutput("overflowPc", pc, 8'h40);
        checkOutput("overflowFault", fault, 1);
        applyStimulus(mk(4'hC, 2'd0, 2'd0, 8'h00), 8'h00, 8'h00, 0);
        applyStimulus(mk(4'h6, 2'd0, 2'd0, 8'h00), 8'h00, 8'h00, 0);
        applyStimulus(mk(4'hE, 2'd0, 2'd0, 8'h05), 8'h00, 8'h00, 0);
        applyIdle(2);
        checkOutput("haltPc", pc, 8'h40);

        // Return with an empty stack.
        doReset();
        applyStimulus(mk(4'hC, 2'd0, 2'd0, 8'h00), 8'h00, 8'h00, 0);
        checkOutput("underflowFault", fault, 1);
        checkOutput("underflowPc", pc, 0);

        // Stalls, then a reset that abandons an in-flight load.
        doReset();
        applyStimulus(mk(4'hF, 2'd0, 2'd0, 8'h05), 8'h00, 8'h00, 0);
        applyIdle(2);
        applyStimulus(mk(4'hF, 2'd1, 2'd0, 8'h07), 8'h00, 8'h00, 0);
        applyIdle(2);
        checkOutput("stallPc", pc, 2);
        memQ.push_back('{addr: 8'h07, data: 8'h00, wr: 1'b0});
        instr = mk(4'hD, 2'd3, 2'd0, 8'h07); instrValid = 1'b1; fromDataMemory = 8'hC3;
        @(posedge clk); #1;
        instrValid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        checkOutput("abortReq", memReq, 1);
        doReset();
        applyStimulus(mk(4'h6, 2'd3, 2'd0, 8'h00), 8'h00, 8'h00, 0);
        applyStimulus(mk(4'h6, 2'd1, 2'd0, 8'h00), 8'h00, 8'h00, 0);

        // Random programs, steering clear of stack faults so the run keeps executing.
        doReset();
        for (int n = 0; n < 300; n++) begin
            op = 4'($urandom_range(0, 15));
            if (op == 4'hB && mStack.size() >= SD) op = 4'h0;
            if (op == 4'hC && mStack.size() == 0) op = 4'h0;
            applyStimulus(mk(op, 2'($urandom), 2'($urandom), 8'($urandom)),
                          8'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
            if ($urandom_range(0, 7) == 0) applyIdle(int'($urandom_range(1, 2)));
        end
        for (int r = 0; r < 4; r++) applyStimulus(mk(4'h6, 2'(r), 2'd0, 8'h00), 8'h00, 8'h00, 0);

        @(posedge clk); #1;
        checkOutput("outQDrained", outQ.size(), 0);
        checkOutput("memQDrained", memQ.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
